accu_m_diff: RTL

- Inverse of the modulo-M phase accumulator: takes a stream of modulo-M accumulated samples x[n] and recovers the per-step increment d[n] = (x[n] - x[n-1]) mod M.
- Used on the receive/measurement side of phase/NCO chains to recover frequency words and check step legality.
- Single-cycle registered datapath with a two-state priming FSM, range checking and step-limit checking.

---
 rtl/accu_m_diff_if.sv | 27 ++
 rtl/accu_m_diff.sv | 117 +++++++++++
 2 files changed

// File: rtl/accu_m_diff_if.sv
// Bus interface for accu_m_diff: sample input side and recovered-increment outputs.
// The optional chk_err signal exists only when ACCU_M_DIFF_CHK_EN is defined.
interface accu_m_diff_if #(
   parameter int W = 7
);
   logic         en;
   logic         clr;
   logic [W-1:0] x;
   logic [W-1:0] d;
   logic         d_valid;
   logic         step_err;
   logic         range_err;
   logic         primed;
`ifdef ACCU_M_DIFF_CHK_EN
   logic         chk_err;

   modport master (output en, clr, x,
                   input  d, d_valid, step_err, range_err, primed, chk_err);
   modport slave  (input  en, clr, x,
                   output d, d_valid, step_err, range_err, primed, chk_err);
`else
   modport master (output en, clr, x,
                   input  d, d_valid, step_err, range_err, primed);
   modport slave  (input  en, clr, x,
                   output d, d_valid, step_err, range_err, primed);
`endif
endinterface

// File: rtl/accu_m_diff.sv
// accu_m_diff: recovers the per-step increment d = (x[n] - x[n-1]) mod M from a
// stream of modulo-M accumulated samples, with range and step-limit checking.
// Optional macro ACCU_M_DIFF_CHK_EN adds a shadow accumulator self-test (chk_err).
module accu_m_diff #(
   parameter int M    = 100,
   parameter int DMAX = M - 1
) (
   input  logic         clk,
   input  logic         rst,
   accu_m_diff_if.slave bus
);
   localparam int         W      = $clog2(M);
   localparam logic [W:0] M_W    = (W+1)'(M);
   localparam logic [W:0] DMAX_W = (W+1)'(DMAX);

   localparam logic [0:0] S_EMPTY  = 1'b0;
   localparam logic [0:0] S_PRIMED = 1'b1;

   logic [0:0]   state;
   logic [W-1:0] prev;
   logic [W-1:0] d_q;
   logic         d_valid_q;
   logic         step_err_q;
   logic         range_err_q;
   logic         primed_q;

   logic         in_range;
   logic [W:0]   x_ext;
   logic [W:0]   prev_ext;
   logic [W:0]   diff;

   assign in_range = ({1'b0, bus.x} < M_W);

   // Modular difference in W+1 bits so x + M - prev never wraps through 2^W.
   always_comb begin
      // NOTE: every combinational output is assigned before any branch, so no latch can be inferred.
      x_ext    = {1'b0, bus.x};
      prev_ext = {1'b0, prev};
      diff     = x_ext - prev_ext;
      if (x_ext < prev_ext) diff = x_ext + M_W - prev_ext;
   end

   // Priming FSM, reference sample, registered increment and status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_EMPTY;
         prev        <= '0;
         d_q         <= '0;
         d_valid_q   <= 1'b0;
         step_err_q  <= 1'b0;
         range_err_q <= 1'b0;
         primed_q    <= 1'b0;
      end else begin
         // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
         d_valid_q  <= 1'b0;
         step_err_q <= 1'b0;
         if (bus.clr) begin
            // Restart wins over a simultaneous sample; d keeps its last value.
            state       <= S_EMPTY;
            primed_q    <= 1'b0;
            range_err_q <= 1'b0;
         end else if (bus.en) begin
            if (!in_range) begin
               // Out-of-range samples are dropped; only the sticky flag records them.
               range_err_q <= 1'b1;
            end else if (state == S_EMPTY) begin
               prev     <= bus.x;
               state    <= S_PRIMED;
               primed_q <= 1'b1;
            end else begin
               prev       <= bus.x;
               d_q        <= diff[W-1:0];
               d_valid_q  <= 1'b1;
               step_err_q <= (diff > DMAX_W);
            end
         end
      end
   end

   assign bus.d         = d_q;
   assign bus.d_valid   = d_valid_q;
   assign bus.step_err  = step_err_q;
   assign bus.range_err = range_err_q;
   assign bus.primed    = primed_q;

`ifdef ACCU_M_DIFF_CHK_EN
   logic [W-1:0] shadow;
   logic [W:0]   shadow_sum;
   logic         chk_err_q;

   // Shadow accumulator re-integrates the recovered increment modulo M.
   always_comb begin
      shadow_sum = {1'b0, shadow} + diff;
      if (shadow_sum >= M_W) shadow_sum = shadow_sum - M_W;
   end

   // Load shadow on priming, advance it per increment, flag any disagreement with x.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow    <= '0;
         chk_err_q <= 1'b0;
      end else if (bus.clr) begin
         chk_err_q <= 1'b0;
      end else if (bus.en && in_range) begin
         if (state == S_EMPTY) begin
            shadow <= bus.x;
         end else begin
            shadow <= shadow_sum[W-1:0];
            if (shadow_sum[W-1:0] != bus.x) chk_err_q <= 1'b1;
         end
      end
   end

   assign bus.chk_err = chk_err_q;
`endif

endmodule
